enemy_motion_ctrl: RTL and testbench

- Upstream stage of the enemy sprite datapath; owns the authoritative position and visibility of the 10 enemies.
- Once per frame it requests an erase pass from the draw path and waits for it to finish.
- It then advances every enemy downward and respawns any enemy that leaves the bottom of the 160x120 playfield at a pseudo-random column.
- It publishes the new coordinates with a one-cycle load strobe consumed by the datapath's coordinate register.

---
 rtl/enemy_pkg.sv | 34 +++
 rtl/enemy_lfsr.sv | 20 ++
 rtl/enemy_motion_ctrl.sv | 109 ++++++++++
 tb/tb_enemy_motion_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared constants, state encoding and helpers for the enemy motion controller.
// Optional respawn of killed enemies is controlled by ENEMY_RESPAWN_EN (see enemy_motion_ctrl).
package enemy_pkg;

  localparam int N_ENEMY     = 10;
  localparam int SPRITE_SIZE = 5;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int Y_LIMIT     = SCREEN_H - SPRITE_SIZE;
  localparam int STEP        = 1;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    LOAD  = 2'd3
  } state_e;

  // Enemy 0 sits in the least significant byte.
  localparam logic [8*N_ENEMY-1:0] RESET_X = {
    8'd142, 8'd12, 8'd2, 8'd42, 8'd32, 8'd72, 8'd122, 8'd62, 8'd82, 8'd102
  };

  // Folds the upper half of the LFSR range down so a 5-wide sprite stays on screen.
  function automatic logic [7:0] respawn_x(input logic [7:0] lfsr);
    logic [7:0] x;
    if (lfsr[7]) x = {1'b0, lfsr[6:0]} + 8'd28;
    else         x = lfsr;
    return x;
  endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every clock outside reset.
module enemy_lfsr
  import enemy_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seed,
  output logic [7:0] lfsr
);

  logic feedback;

  assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= seed;
    else          lfsr <= {lfsr[6:0], feedback};
  end

endmodule

// File: rtl/enemy_motion_ctrl.sv
// Per-frame enemy motion: request erase, step every enemy down one at a time, publish.
// Define ENEMY_RESPAWN_EN to let wrapping enemies become visible again.
module enemy_motion_ctrl
  import enemy_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 erase_done,
  input  logic [N_ENEMY-1:0]   hit,
  output logic                 op_erase,
  output logic                 load_coord,
  output logic [8*N_ENEMY-1:0] x_bus,
  output logic [8*N_ENEMY-1:0] y_bus,
  output logic [N_ENEMY-1:0]   visible,
  output logic                 wave_clear
);

  // Handshake: frame_tick is accepted only in IDLE, erase_done only in ERASE;
  // load_coord is a single-cycle strobe and x_bus/y_bus are valid in that cycle.

  state_e               state_q, state_d;
  logic [3:0]           idx_q;
  logic [6:0]           ofs;
  logic [8*N_ENEMY-1:0] x_q, y_q;
  logic [N_ENEMY-1:0]   vis_q, vis_d;
  logic                 wc_q;
  logic [7:0]           lfsr;
  logic [7:0]           y_cur;
  logic [8:0]           y_new;
  logic                 wrap;
  logic [7:0]           rsp_x;
  logic                 last_idx;

  enemy_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .lfsr    (lfsr)
  );

  assign ofs      = {idx_q, 3'b000};
  assign y_cur    = y_q[ofs +: 8];
  assign y_new    = {1'b0, y_cur} + 9'(STEP);
  assign wrap     = (y_new > 9'(Y_LIMIT));
  assign rsp_x    = respawn_x(lfsr);
  assign last_idx = (idx_q == 4'(N_ENEMY - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    op_erase   = 1'b0;
    load_coord = 1'b0;
    case (state_q)
      IDLE:  if (frame_tick) state_d = ERASE;
      ERASE: begin
        op_erase = 1'b1;
        if (erase_done) state_d = MOVE;
      end
      MOVE:  if (last_idx) state_d = LOAD;
      LOAD: begin
        load_coord = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A hit in the same cycle as a respawn keeps the enemy dead.
  always_comb begin
    vis_d = vis_q & ~hit;
`ifdef ENEMY_RESPAWN_EN
    if ((state_q == MOVE) && wrap && !hit[idx_q]) vis_d[idx_q] = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      x_q   <= RESET_X;
      y_q   <= '0;
      vis_q <= '1;
      wc_q  <= 1'b0;
    end else begin
      vis_q <= vis_d;
      wc_q  <= (vis_q == '0);
      if ((state_q == ERASE) && erase_done) idx_q <= '0;
      else if ((state_q == MOVE) && !last_idx) idx_q <= idx_q + 4'd1;
      if (state_q == MOVE) begin
        if (wrap) begin
          y_q[ofs +: 8] <= 8'd0;
          x_q[ofs +: 8] <= rsp_x;
        end else begin
          y_q[ofs +: 8] <= y_new[7:0];
        end
      end
    end
  end

  assign x_bus      = x_q;
  assign y_bus      = y_q;
  assign visible    = vis_q;
  assign wave_clear = wc_q;

endmodule

// File: tb/tb_enemy_motion_ctrl.sv
// Directed frame sequence with randomized gaps/hits, checked against a frame-level model.
module tb_enemy_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        erase_done = 1'b0;
  logic [9:0]  hit = '0;
  logic        op_erase, load_coord, wave_clear;
  logic [79:0] x_bus, y_bus;
  logic [9:0]  visible;

  enemy_motion_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .erase_done (erase_done),
    .hit        (hit),
    .op_erase   (op_erase),
    .load_coord (load_coord),
    .x_bus      (x_bus),
    .y_bus      (y_bus),
    .visible    (visible),
    .wave_clear (wave_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         rx_tab[10] = '{102, 82, 62, 122, 72, 32, 42, 2, 12, 142};
  int         mx[10];
  int         my[10];
  logic [9:0] mvis;
  logic       mwc;
  logic [7:0] lfsr_m;
  bit         mv_active;
  int         mv_idx;
  bit         mv_wrap;
  logic [9:0] hit_all_left;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int model_respawn(input logic [7:0] v);
    int u;
    u = int'(v);
    if (u < 128) return u;
    return u - 128 + 28;
  endfunction

  function automatic logic [79:0] model_bus(input bit is_x);
    logic [79:0] b;
    for (int i = 0; i < 10; i++) b[i*8 +: 8] = is_x ? 8'(mx[i]) : 8'(my[i]);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      mx[i] = rx_tab[i];
      my[i] = 0;
    end
    mvis      = 10'h3FF;
    mwc       = 1'b0;
    lfsr_m    = 8'hA5;
    mv_active = 1'b0;
    mv_wrap   = 1'b0;
    mv_idx    = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic tick();
    logic [9:0] nv;
    logic       nwc;
    nwc = (mvis == 10'h000);
    nv  = mvis & ~hit;
`ifdef ENEMY_RESPAWN_EN
    if (mv_active && mv_wrap && !hit[mv_idx]) nv[mv_idx] = 1'b1;
`endif
    mvis   = nv;
    mwc    = nwc;
    lfsr_m = lfsr_next(lfsr_m);
    @(posedge clk);
    #1;
  endtask

  task automatic check_vis(input string tag);
    check({tag, ".visible"}, 80'(visible), 80'(mvis));
    check({tag, ".wave_clear"}, 80'(wave_clear), 80'(mwc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".op_erase"}, 80'(op_erase), 80'(0));
    check({tag, ".load_coord"}, 80'(load_coord), 80'(0));
    check({tag, ".visible"}, 80'(visible), 80'(10'h3FF));
    check({tag, ".wave_clear"}, 80'(wave_clear), 80'(0));
    check({tag, ".x_bus"}, x_bus,
          {8'd142, 8'd12, 8'd2, 8'd42, 8'd32, 8'd72, 8'd122, 8'd62, 8'd82, 8'd102});
    check({tag, ".y_bus"}, y_bus, 80'(0));
  endtask

  // One full frame; returns early if abort_idx triggers an asynchronous reset.
  task automatic do_frame(input int gap, input int hit_idx, input logic [9:0] hit_val,
                          input bit extra_ticks, input int abort_idx);
    int lf_rsp;
    int ynew;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("erase_enter", 80'(op_erase), 80'(1));
    for (int g = 0; g < gap; g++) begin
      if (extra_ticks && g == 0) frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("erase_hold", 80'(op_erase), 80'(1));
    end
    erase_done = 1'b1;
    tick();
    erase_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("move_no_load", 80'(load_coord), 80'(0));
      check("move_no_erase", 80'(op_erase), 80'(0));
      if (i == abort_idx) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #2;
        reset_n = 1'b1;
        return;
      end
      if (extra_ticks && i == 3) frame_tick = 1'b1;
      if (i == hit_idx) hit = hit_val;
      lf_rsp  = model_respawn(lfsr_m);
      ynew    = my[i] + 1;
      mv_idx  = i;
      mv_wrap = (ynew > 115);
      if (mv_wrap) begin
        my[i] = 0;
        mx[i] = lf_rsp;
      end else begin
        my[i] = ynew;
      end
      mv_active = 1'b1;
      tick();
      mv_active  = 1'b0;
      mv_wrap    = 1'b0;
      hit        = '0;
      frame_tick = 1'b0;
      check_vis("move");
    end
    check("load_strobe", 80'(load_coord), 80'(1));
    check("load_x", x_bus, model_bus(1'b1));
    check("load_y", y_bus, model_bus(1'b0));
    tick();
    check("load_single", 80'(load_coord), 80'(0));
    check("idle_after_load", 80'(op_erase), 80'(0));
    check_vis("idle");
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // First frame: erase_done five cycles after frame_tick.
    tick();
    do_frame(4, -1, '0, 1'b0, -1);
    check("first_y_all_1", y_bus, {10{8'd1}});
    check("first_x0", 80'(x_bus[7:0]), 80'(102));

    // Frames 2..115 with random erase gaps.
    for (int f = 2; f <= 115; f++) do_frame($urandom_range(0, 5), -1, '0, 1'b0, -1);
    check("y_at_115", y_bus, {10{8'd115}});

    // Frame 116: everybody wraps to the top at an LFSR-derived column.
    do_frame($urandom_range(0, 5), -1, '0, 1'b0, -1);
    check("wrap_y_zero", y_bus, 80'(0));
    for (int i = 0; i < 10; i++)
      check("wrap_x_le_155", 80'(x_bus[i*8 +: 8] <= 8'd155), 80'(1));

    // Kill enemy 3 mid-MOVE; its y keeps advancing with the others.
    do_frame($urandom_range(0, 3), $urandom_range(0, 9), 10'b0000001000, 1'b0, -1);
    check("hit3_visible", 80'(visible), 80'(10'h3F7));
    check("hit3_y_moves", 80'(y_bus[31:24]), 80'(1));

    // Stray frame_ticks during ERASE and MOVE must not add a step.
    do_frame(3, -1, '0, 1'b1, -1);
    check("no_double_step", 80'(y_bus[7:0]), 80'(2));
    for (int f = 0; f < 4; f++)
      do_frame($urandom_range(0, 4), -1, '0, 1'(f[0]), -1);

    // Kill the rest of the wave with random hit bursts while idle.
    for (int k = 0; k < 40 && mvis != 10'h000; k++) begin
      hit_all_left = mvis;
      hit = 10'($urandom_range(0, 1023)) & hit_all_left;
      if (k == 39) hit = '1;
      tick();
      hit = '0;
      check_vis("hit_burst");
    end
    tick();
    check_vis("wave_settle");
    tick();
    check("wave_clear_set", 80'(wave_clear), 80'(1));
    check("visible_zero", 80'(visible), 80'(0));

    // Run to the next wrap.
    for (int f = my[0]; f < 116; f++) do_frame($urandom_range(0, 3), -1, '0, 1'b0, -1);
    tick();
`ifdef ENEMY_RESPAWN_EN
    check("respawn_visible", 80'(visible), 80'(10'h3FF));
    check("respawn_wave_clear", 80'(wave_clear), 80'(0));
`else
    check("no_respawn_visible", 80'(visible), 80'(0));
    check("no_respawn_wave_clear", 80'(wave_clear), 80'(1));
`endif

    // Asynchronous reset at idx 4, then a clean first frame.
    do_frame(2, -1, '0, 1'b0, 4);
    tick();
    check_reset_outputs("post_reset");
    do_frame(4, -1, '0, 1'b0, -1);
    check("reframe_y_all_1", y_bus, {10{8'd1}});
    check("reframe_x0", 80'(x_bus[7:0]), 80'(102));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
